botones_acondicionador: RTL and testbench

- Input conditioning stage directly upstream of interfaz_botones_alu.
- Takes the raw, asynchronous, bouncing push-button lines from the board.
- Per button: synchronises to clk, debounces with a counter-based state machine, and emits a single-cycle press pulse plus a clean level.
- push_pulse drives the push[4:0] input of interfaz_botones_alu, so one physical press equals exactly one selection event.

---
 rtl/botones_acondicionador.sv | 53 +++++
 tb/tb_botones_acondicionador.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/botones_acondicionador.sv
// botones_acondicionador: per-button two-flop synchroniser, counter debouncer and press-pulse generator
module botones_acondicionador #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] push_raw,
  output logic [N_BTN-1:0] push_level,
  output logic [N_BTN-1:0] push_pulse,
  output logic             any_pulse
);
  typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} state_e;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  for (genvar g = 0; g < N_BTN; g++) begin : btn
    logic             sync1_q, sync2_q, pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           state_q, state_d;
    // any return of sync2 to the stable value drops the partial count
    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      pulse_d = 1'b0;
      if (sync2_q != (state_q == PRESSED)) begin
        if (cnt_q == CNT_MAX) begin
          state_d = sync2_q ? PRESSED : RELEASED;
          pulse_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        state_q <= RELEASED;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        sync1_q <= push_raw[g];
        sync2_q <= sync1_q;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
      end
    end
    assign push_level[g] = (state_q == PRESSED);
    assign push_pulse[g] = pulse_q;
  end
  assign any_pulse = |push_pulse;
endmodule

// File: tb/tb_botones_acondicionador.sv
// tb_botones_acondicionador: directed and random stimulus against a sliding-window reference model
module tb_botones_acondicionador;
  localparam int N = 5;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] push_raw = '0;
  logic [N-1:0] push_level, push_pulse;
  logic any_pulse;
  int total = 0;
  int bad = 0;
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_pulse = '0;
  logic [N-1:0] pipe[$];
  bit hist[N][$];
  always #5 clk = ~clk;
  botones_acondicionador #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .clk(clk), .rst(rst), .push_raw(push_raw),
    .push_level(push_level), .push_pulse(push_pulse), .any_pulse(any_pulse)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // a button's level flips once the last D values seen after synchronisation all disagree with it
  task automatic model_edge(input logic r, input logic [N-1:0] raw);
    logic [N-1:0] seen, lv, pl;
    bit all_diff;
    if (r) begin
      pipe.delete();
      pipe.push_back('0);
      pipe.push_back('0);
      m_level = '0;
      m_pulse = '0;
      for (int b = 0; b < N; b++) hist[b].delete();
    end else begin
      seen = pipe.pop_front();
      pipe.push_back(raw);
      lv = m_level;
      pl = '0;
      for (int b = 0; b < N; b++) begin
        hist[b].push_back(seen[b]);
        if (hist[b].size() > D) void'(hist[b].pop_front());
        all_diff = (hist[b].size() == D);
        foreach (hist[b][k]) if (hist[b][k] == m_level[b]) all_diff = 0;
        if (all_diff) begin
          lv[b] = seen[b];
          pl[b] = seen[b] & ~m_level[b];
          hist[b].delete();
        end
      end
      m_level = lv;
      m_pulse = pl;
    end
  endtask
  task automatic cyc(input logic r, input logic [N-1:0] raw);
    rst = r;
    push_raw = raw;
    @(posedge clk);
    model_edge(r, raw);
    @(negedge clk);
    check("level", push_level, m_level);
    check("pulse", push_pulse, m_pulse);
    check("any", any_pulse, |m_pulse);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0);
  endtask
  initial begin
    int lat, np;
    logic [N-1:0] first, raw;
    bit held;
    pipe.push_back('0);
    pipe.push_back('0);
    cyc(1, '0);
    cyc(1, '0);
    check("rst_level", push_level, 0);
    check("rst_pulse", push_pulse, 0);
    lat = -1; np = 0;
    for (int k = 0; k < 12; k++) begin
      cyc(0, 5'b00001);
      if (push_pulse != 0) begin np++; if (lat < 0) lat = k; end
    end
    check("press_lat", lat, 5);
    check("press_npulse", np, 1);
    check("press_level", push_level, 5'b00001);
    lat = -1; np = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(0, '0);
      if (push_pulse != 0) np++;
      if (!push_level[0] && lat < 0) lat = k;
    end
    check("release_lat", lat, 5);
    check("release_npulse", np, 0);
    for (int k = 0; k < 8; k++) cyc(0, 5'b00001);
    held = 1;
    cyc(0, '0);
    cyc(0, '0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 5'b00001);
      if (!push_level[0]) held = 0;
    end
    check("glitch_held", held, 1);
    idle(10);
    np = 0;
    cyc(0, 5'b00100); np += int'(push_pulse != 0);
    cyc(0, 5'b00000); np += int'(push_pulse != 0);
    cyc(0, 5'b00100); np += int'(push_pulse != 0);
    cyc(0, 5'b00000); np += int'(push_pulse != 0);
    lat = -1; first = '0;
    for (int k = 0; k < 12; k++) begin
      cyc(0, 5'b00100);
      if (push_pulse != 0) begin np++; if (lat < 0) begin lat = k; first = push_pulse; end end
    end
    check("bounce_lat", lat, 5);
    check("bounce_val", first, 5'b00100);
    check("bounce_npulse", np, 1);
    idle(10);
    first = '0;
    for (int k = 0; k < 10; k++) begin
      cyc(0, 5'b10010);
      if (push_pulse != 0 && first == 0) first = push_pulse;
    end
    check("simul_pulse", first, 5'b10010);
    check("simul_level", push_level, 5'b10010);
    idle(10);
    for (int k = 0; k < 3; k++) cyc(0, 5'b01000);
    cyc(1, 5'b01000);
    check("midrst_level", push_level, 0);
    check("midrst_pulse", push_pulse, 0);
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      cyc(0, 5'b01000);
      if (push_pulse[3] && lat < 0) lat = k;
    end
    check("midrst_lat", lat, 5);
    idle(10);
    np = 0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 8; k++) begin cyc(0, 5'b00010); np += int'(any_pulse); end
      for (int k = 0; k < 8; k++) begin cyc(0, '0); np += int'(any_pulse); end
    end
    check("integ_npulse", np, 3);
    raw = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) raw[b] = ~raw[b];
      cyc($urandom_range(0, 99) == 0, raw);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
